// File: rtl/onchip_mem_arbiter_pkg.sv
// onchip_mem_arb_pkg: shared owner type, width defaults and burst counter helper
package onchip_mem_arb_pkg;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    // Consecutive-grant counter: restarts at 1 on a port change, saturates at max
    function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic same, input logic [3:0] max);
        return !same ? 4'd1 : (cnt >= max ? cnt : cnt + 4'd1);
    endfunction
endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: two Avalon-MM master ports plus the single-port RAM command bus
//   a_*/b_*  : address, byteenable, read, write, writedata in; waitrequest, readdata, readdatavalid out
//   ram_*    : address, byteenable, chipselect, write, writedata, clken out; readdata in
interface onchip_mem_arbiter_if
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int BE_W = DATA_W / 8;
    logic [ADDR_W-1:0] a_address, b_address, ram_address;
    logic [BE_W-1:0]   a_byteenable, b_byteenable, ram_byteenable;
    logic [DATA_W-1:0] a_writedata, b_writedata, ram_writedata;
    logic [DATA_W-1:0] a_readdata, b_readdata, ram_readdata;
    logic              a_read, a_write, a_waitrequest, a_readdatavalid;
    logic              b_read, b_write, b_waitrequest, b_readdatavalid;
    logic              ram_chipselect, ram_write, ram_clken;
    modport slave (
        input  a_address, a_byteenable, a_read, a_write, a_writedata,
        output a_waitrequest, a_readdata, a_readdatavalid,
        input  b_address, b_byteenable, b_read, b_write, b_writedata,
        output b_waitrequest, b_readdata, b_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata
    );
    modport master (
        output a_address, a_byteenable, a_read, a_write, a_writedata,
        input  a_waitrequest, a_readdata, a_readdatavalid,
        output b_address, b_byteenable, b_read, b_write, b_writedata,
        input  b_waitrequest, b_readdata, b_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata
    );
endinterface

// File: rtl/onchip_mem_rd_tag_pipe.sv
// onchip_mem_rd_tag_pipe: RD_LATENCY-deep shift of {valid, owner} tags for reads in flight
//   push_i/push_owner_i : granted read enters stage 0
//   pop_valid_o/pop_owner_o : tag leaving the last stage (RAM data valid this cycle)
//   any_in_flight_o : at least one tag still in the pipe
module onchip_mem_rd_tag_pipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push_i,
    input  owner_t push_owner_i,
    output logic   pop_valid_o,
    output owner_t pop_owner_o,
    output logic   any_in_flight_o
);
    logic [RD_LATENCY-1:0] vld_q;
    owner_t                own_q [RD_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) own_q[i] <= OWN_A;
        end else begin
            vld_q[0] <= push_i;
            own_q[0] <= push_owner_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign pop_valid_o     = vld_q[RD_LATENCY-1];
    assign pop_owner_o     = own_q[RD_LATENCY-1];
    assign any_in_flight_o = |vld_q;
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin, burst-bounded sharing of one single-port RAM between two Avalon-MM masters
//   clk, reset_n (async active-low), halt (accept no new commands)
//   bus : slave side of onchip_mem_arbiter_if (ports A/B and the RAM command bus)
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic halt,
    onchip_mem_arbiter_if.slave bus
);
    localparam int         BE_W = DATA_W / 8;
    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    owner_t            last_q, last_d, win, pop_owner;
    logic [3:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              req_a, req_b, keep, gnt_a, gnt_b, gnt, sel_rd, sel_wr, pop_valid, in_flight;

    always_comb begin
        req_a   = reset_n & ~halt & (bus.a_read | bus.a_write);
        req_b   = reset_n & ~halt & (bus.b_read | bus.b_write);
        // On a tie the last winner keeps the bus only inside an unfinished burst;
        // burst_q==0 after reset means no owner, so A (the non-last port) wins.
        keep    = (burst_q != 4'd0) && (burst_q < MAXB);
        gnt_a   = req_a & (~req_b | ((last_q == OWN_A) == keep));
        gnt_b   = req_b & ~gnt_a;
        gnt     = gnt_a | gnt_b;
        win     = gnt_b ? OWN_B : OWN_A;
        sel_rd  = gnt_b ? bus.b_read : bus.a_read;
        sel_wr  = gnt_b ? bus.b_write : bus.a_write;
        addr_d  = !gnt ? addr_q : gnt_b ? bus.b_address : bus.a_address;
        be_d    = !gnt ? be_q : gnt_b ? bus.b_byteenable : bus.a_byteenable;
        wd_d    = !gnt ? wd_q : gnt_b ? bus.b_writedata : bus.a_writedata;
        burst_d = gnt ? burst_next(burst_q, win == last_q, MAXB) : burst_q;
        last_d  = gnt ? win : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= OWN_B;
            burst_q <= 4'd0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
        end
    end

    // read&write together is resolved as a write, so it must not create a tag
    onchip_mem_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tags (
        .clk            (clk),
        .reset_n        (reset_n),
        .push_i         (gnt & sel_rd & ~sel_wr),
        .push_owner_i   (win),
        .pop_valid_o    (pop_valid),
        .pop_owner_o    (pop_owner),
        .any_in_flight_o(in_flight)
    );

    assign bus.a_waitrequest   = ~gnt_a;
    assign bus.b_waitrequest   = ~gnt_b;
    assign bus.a_readdatavalid = pop_valid & (pop_owner == OWN_A);
    assign bus.b_readdatavalid = pop_valid & (pop_owner == OWN_B);
    assign bus.a_readdata      = bus.ram_readdata;
    assign bus.b_readdata      = bus.ram_readdata;
    assign bus.ram_address     = addr_d;
    assign bus.ram_byteenable  = be_d;
    assign bus.ram_writedata   = wd_d;
    assign bus.ram_chipselect  = gnt;
    assign bus.ram_write       = gnt & sel_wr;
    assign bus.ram_clken       = ~halt | in_flight;

    a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(bus.a_read && bus.a_write));
    b_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(bus.b_read && bus.b_write));
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: random and directed stimulus checked against a behavioural arbiter/RAM model
module tb_onchip_mem_arbiter;
    import onchip_mem_arb_pkg::*;
    localparam int AW = 12, DW = 32, MB = 4, RDL = 1;

    logic clk = 1'b0, reset_n = 1'b0, halt = 1'b0;
    int   errors = 0, checks = 0, cyc = 0;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .halt(halt), .bus(bus));
    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .halt(1'b0), .bus(bus1));

    // second instance: both ports read every cycle, only the grant pattern is observed
    assign bus1.a_address = '0;
    assign bus1.a_byteenable = '1;
    assign bus1.a_read = 1'b1;
    assign bus1.a_write = 1'b0;
    assign bus1.a_writedata = '0;
    assign bus1.b_address = 12'h001;
    assign bus1.b_byteenable = '1;
    assign bus1.b_read = 1'b1;
    assign bus1.b_write = 1'b0;
    assign bus1.b_writedata = '0;
    assign bus1.ram_readdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM: registered address, unregistered q
    logic [31:0] ram [4096];
    logic [11:0] ram_ar = '0;
    assign bus.ram_readdata = ram[ram_ar];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_chipselect && bus.ram_clken) begin
                if (bus.ram_write)
                    for (int k = 0; k < 4; k++) if (bus.ram_byteenable[k]) ram[bus.ram_address][8*k+:8] = bus.ram_writedata[8*k+:8];
                ram_ar = bus.ram_address;
            end
        end
    end

    // behavioural model: memory image, last winner, run length, queue of expected responses
    typedef struct {int due; int own; logic [31:0] data;} rsp_t;
    rsp_t        q[$];
    logic [31:0] mm [4096];
    initial begin
        int last, cnt, w;
        logic ra, rb, va, vb, wr, infl;
        logic [11:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        last = 1; cnt = 0;
        for (int i = 0; i < 4096; i++) mm[i] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_a_wait", bus.a_waitrequest, 1);
                chk("rst_b_wait", bus.b_waitrequest, 1);
                chk("rst_a_valid", bus.a_readdatavalid, 0);
                chk("rst_b_valid", bus.b_readdatavalid, 0);
                chk("rst_cs", bus.ram_chipselect, 0);
                last = 1; cnt = 0;
                q.delete();
            end else begin
                ra = (bus.a_read | bus.a_write) & ~halt;
                rb = (bus.b_read | bus.b_write) & ~halt;
                if (ra && rb) w = (cnt > 0 && cnt < MB) ? last : 1 - last;
                else w = ra ? 0 : rb ? 1 : -1;
                chk("a_wait", bus.a_waitrequest, w != 0);
                chk("b_wait", bus.b_waitrequest, w != 1);
                chk("ram_cs", bus.ram_chipselect, w >= 0);
                infl = q.size() > 0;
                chk("ram_clken", bus.ram_clken, !halt || infl);
                va = q.size() > 0 && q[0].due == cyc && q[0].own == 0;
                vb = q.size() > 0 && q[0].due == cyc && q[0].own == 1;
                chk("a_valid", bus.a_readdatavalid, va);
                chk("b_valid", bus.b_readdatavalid, vb);
                if (va) chk("a_rdata", bus.a_readdata, q[0].data);
                if (vb) chk("b_rdata", bus.b_readdata, q[0].data);
                if (va || vb) void'(q.pop_front());
                if (w >= 0) begin
                    ad = w == 1 ? bus.b_address : bus.a_address;
                    wr = w == 1 ? bus.b_write : bus.a_write;
                    be = w == 1 ? bus.b_byteenable : bus.a_byteenable;
                    wd = w == 1 ? bus.b_writedata : bus.a_writedata;
                    chk("ram_addr", bus.ram_address, ad);
                    chk("ram_write", bus.ram_write, wr);
                    if (wr) begin
                        chk("ram_be", bus.ram_byteenable, be);
                        chk("ram_wdata", bus.ram_writedata, wd);
                        for (int k = 0; k < 4; k++) if (be[k]) mm[ad][8*k+:8] = wd[8*k+:8];
                    end else q.push_back('{cyc + RDL, w, mm[ad]});
                    cnt = (w == last) ? (cnt < MB ? cnt + 1 : cnt) : 1;
                    last = w;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic p, input logic rd, input logic wr, input logic [11:0] ad, input logic [3:0] be, input logic [31:0] d);
        if (p) begin
            bus.b_read = rd; bus.b_write = wr; bus.b_address = ad; bus.b_byteenable = be; bus.b_writedata = d;
        end else begin
            bus.a_read = rd; bus.a_write = wr; bus.a_address = ad; bus.a_byteenable = be; bus.a_writedata = d;
        end
    endtask

    task automatic idle();
        cmd(0, 0, 0, '0, '0, '0);
        cmd(1, 0, 0, '0, '0, '0);
    endtask

    task automatic rand_port(input logic p, output logic act);
        logic wr;
        act = $urandom_range(3) != 0;
        wr = 1'($urandom_range(1));
        if (act) cmd(p, ~wr, wr, 12'($urandom_range(15)), 4'($urandom_range(15)), $urandom);
        else cmd(p, 0, 0, '0, '0, '0);
    endtask

    initial begin
        logic act_a, act_b, acc_a, acc_b;
        idle();
        repeat (3) step();
        reset_n = 1'b1;
        // single write then read on A
        cmd(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk("t1_wr_wait", bus.a_waitrequest, 0);
        step(); cmd(0, 1, 0, 12'h010, 4'hF, '0);
        @(negedge clk); chk("t1_rd_wait", bus.a_waitrequest, 0);
        step(); idle();
        @(negedge clk); chk("t1_valid", bus.a_readdatavalid, 1); chk("t1_data", bus.a_readdata, 32'hDEADBEEF);
        // byte-lane write merge
        step(); cmd(0, 0, 1, 12'h020, 4'hF, 32'hFFFFFFFF);
        step(); cmd(0, 0, 1, 12'h020, 4'b0010, 32'h0000AB00);
        step(); cmd(0, 1, 0, 12'h020, 4'hF, '0);
        step(); idle();
        @(negedge clk); chk("t6_valid", bus.a_readdatavalid, 1); chk("t6_data", bus.a_readdata, 32'hFFFFABFF);
        // halt right after a B read
        step(); cmd(0, 0, 1, 12'h123, 4'hF, 32'h12345678);
        step(); idle(); cmd(1, 1, 0, 12'h123, 4'hF, '0);
        @(negedge clk); chk("t4_b_wait", bus.b_waitrequest, 0);
        step(); idle(); halt = 1'b1; cmd(0, 1, 0, 12'h010, 4'hF, '0);
        @(negedge clk); chk("t4_b_valid", bus.b_readdatavalid, 1); chk("t4_b_data", bus.b_readdata, 32'h12345678);
        chk("t4_a_wait", bus.a_waitrequest, 1);
        repeat (3) begin step(); @(negedge clk); chk("t4_a_wait_halt", bus.a_waitrequest, 1); end
        step(); halt = 1'b0;
        @(negedge clk); chk("t4_a_wait_go", bus.a_waitrequest, 0);
        step(); idle();
        @(negedge clk); chk("t4_a_valid", bus.a_readdatavalid, 1); chk("t4_a_data", bus.a_readdata, 32'hDEADBEEF);
        // reset while a B read is in flight
        step(); cmd(1, 1, 0, 12'h123, 4'hF, '0);
        @(negedge clk); chk("t5_b_wait", bus.b_waitrequest, 0);
        step(); idle(); reset_n = 1'b0;
        @(negedge clk); chk("t5_a_valid", bus.a_readdatavalid, 0); chk("t5_b_valid", bus.b_readdatavalid, 0);
        step(); reset_n = 1'b1; cmd(0, 1, 0, 12'h010, 4'hF, '0); cmd(1, 1, 0, 12'h123, 4'hF, '0);
        @(negedge clk); chk("t5_tie_a", bus.a_waitrequest, 0); chk("t5_tie_b", bus.b_waitrequest, 1);
        chk("t5_no_valid", bus.b_readdatavalid, 0);
        // continuous reads from both ports right after reset: bursts of 4 vs strict alternation
        step(); idle(); reset_n = 1'b0;
        step(); reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd(0, 1, 0, 12'(i), 4'hF, '0);
            cmd(1, 1, 0, 12'(i + 16), 4'hF, '0);
            @(negedge clk);
            chk("t2_a_wait", bus.a_waitrequest, (i / 4) % 2);
            chk("t2_b_wait", bus.b_waitrequest, 1 - (i / 4) % 2);
            chk("t3_a_wait", bus1.a_waitrequest, i % 2);
            chk("t3_b_wait", bus1.b_waitrequest, 1 - i % 2);
            step();
        end
        idle();
        // random traffic with random halt; commands held until accepted
        act_a = 1'b0; act_b = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc_a = act_a && !bus.a_waitrequest;
            acc_b = act_b && !bus.b_waitrequest;
            step();
            if (!act_a || acc_a) rand_port(0, act_a);
            if (!act_b || acc_b) rand_port(1, act_b);
            halt = $urandom_range(7) == 0;
        end
        idle(); halt = 1'b0;
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
